// File: rtl/mips_pkg.sv
// Shared constants and FSM encoding for the 16-bit pipelined MIPS datapath.
package mips_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int CNT_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed single-port data RAM with registered read; contents are not reset.
module data_memory #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // rdata only moves on a read, so a finished load stays visible until the next one
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: EX/MEM capture, multi-cycle data-memory access and WB outputs.
// Optional MEM_STAGE_BOUNDS_CHECK_EN turns out-of-range addresses into faults.
module memory_stage #(
    parameter int DATA_W      = mips_pkg::DATA_W,
    parameter int ADDR_W      = 8,
    parameter int REG_W       = mips_pkg::REG_W,
    parameter int MEM_LATENCY = 2
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Valid,
    input  logic [DATA_W-1:0] i_ALU_Result,
    input  logic [DATA_W-1:0] i_Write_Data,
    input  logic [REG_W-1:0]  i_Write_Reg,
    input  logic              i_Sig_MemRead,
    input  logic              i_Sig_MemWrite,
    input  logic              i_Sig_MemtoReg,
    input  logic              i_Sig_RegWrite,
    output logic              o_Stall,
    output logic              o_Valid,
    output logic [DATA_W-1:0] o_Write_Back_Data,
    output logic [REG_W-1:0]  o_Write_Reg,
    output logic              o_Sig_RegWrite,
    output logic              o_Fault
);

    import mips_pkg::*;

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);
    localparam bit               DIRECT = (MEM_LATENCY == 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] cap_alu, cap_wdata;
    logic [REG_W-1:0]  cap_reg;
    logic              cap_read, cap_write, cap_m2r, cap_rw;

    logic [DATA_W-1:0] cur_alu, cur_wdata;
    logic [REG_W-1:0]  cur_reg;
    logic              cur_read, cur_write, cur_m2r, cur_rw;
    logic              cur_load, cur_fault;

    logic              busy, accept, complete, is_mem_in;
    logic              ram_we, ram_re;
    logic [DATA_W-1:0] ram_rdata;

    logic              valid_q, wb_sel_mem, rw_q;
    logic [DATA_W-1:0] wb_alu;
    logic [REG_W-1:0]  reg_q;

    assign busy      = (state_q == BUSY);
    assign is_mem_in = i_Sig_MemRead | i_Sig_MemWrite;
    assign accept    = !busy && i_Valid;
    assign complete  = busy ? (cnt_q == CNT_W'(1)) : (i_Valid && (!is_mem_in || DIRECT));

    // The finishing op comes straight from the inputs in IDLE, or from the capture register in BUSY
    assign cur_alu   = busy ? cap_alu   : i_ALU_Result;
    assign cur_wdata = busy ? cap_wdata : i_Write_Data;
    assign cur_reg   = busy ? cap_reg   : i_Write_Reg;
    assign cur_read  = busy ? cap_read  : i_Sig_MemRead;
    assign cur_write = busy ? cap_write : i_Sig_MemWrite;
    assign cur_m2r   = busy ? cap_m2r   : i_Sig_MemtoReg;
    assign cur_rw    = busy ? cap_rw    : i_Sig_RegWrite;
    assign cur_load  = cur_read && !cur_write;

`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    logic fault_q;

    assign cur_fault = (cur_read || cur_write) && ((cur_alu >> ADDR_W) != '0);
    assign o_Fault   = fault_q;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= complete && cur_fault;
        end
    end
`else
    assign cur_fault = 1'b0;
    assign o_Fault   = 1'b0;
`endif

    assign ram_we = complete && cur_write && !cur_fault;
    assign ram_re = complete && cur_load && !cur_fault;

    data_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_data_memory (
        .clk   (i_Clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (cur_alu[ADDR_W-1:0]),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_Valid && is_mem_in && !DIRECT) begin
                    state_d = BUSY;
                    cnt_d   = LAT_M1;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            cap_alu   <= '0;
            cap_wdata <= '0;
            cap_reg   <= '0;
            cap_read  <= 1'b0;
            cap_write <= 1'b0;
            cap_m2r   <= 1'b0;
            cap_rw    <= 1'b0;
        end else if (accept) begin
            cap_alu   <= i_ALU_Result;
            cap_wdata <= i_Write_Data;
            cap_reg   <= i_Write_Reg;
            cap_read  <= i_Sig_MemRead;
            cap_write <= i_Sig_MemWrite;
            cap_m2r   <= i_Sig_MemtoReg;
            cap_rw    <= i_Sig_RegWrite;
        end
    end

    // A faulting load reads as zero, so the ALU path carries the zero instead of the RAM
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            valid_q    <= 1'b0;
            wb_alu     <= '0;
            wb_sel_mem <= 1'b0;
            reg_q      <= '0;
            rw_q       <= 1'b0;
        end else begin
            valid_q <= complete;
            if (complete) begin
                wb_alu     <= (cur_fault && cur_load && cur_m2r) ? '0 : cur_alu;
                wb_sel_mem <= cur_load && cur_m2r && !cur_fault;
                reg_q      <= cur_reg;
                rw_q       <= cur_rw;
            end
        end
    end

    assign o_Stall           = busy;
    assign o_Valid           = valid_q;
    assign o_Write_Back_Data = wb_sel_mem ? ram_rdata : wb_alu;
    assign o_Write_Reg       = reg_q;
    assign o_Sig_RegWrite    = rw_q && valid_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage built with MEM_LATENCY=3.
// Expectations for out-of-range accesses follow MEM_STAGE_BOUNDS_CHECK_EN.
module tb_memory_stage;

    localparam int LAT = 3;

`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    localparam logic BOUNDS = 1'b1;
`else
    localparam logic BOUNDS = 1'b0;
`endif

    logic        i_Clk = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_Valid = 1'b0;
    logic [15:0] i_ALU_Result = '0;
    logic [15:0] i_Write_Data = '0;
    logic [2:0]  i_Write_Reg = '0;
    logic        i_Sig_MemRead = 1'b0;
    logic        i_Sig_MemWrite = 1'b0;
    logic        i_Sig_MemtoReg = 1'b0;
    logic        i_Sig_RegWrite = 1'b0;
    logic        o_Stall, o_Valid, o_Sig_RegWrite, o_Fault;
    logic [15:0] o_Write_Back_Data;
    logic [2:0]  o_Write_Reg;

    int checks = 0;
    int failures = 0;

    memory_stage #(.DATA_W(16), .ADDR_W(8), .REG_W(3), .MEM_LATENCY(LAT)) dut (
        .i_Clk             (i_Clk),
        .i_Reset           (i_Reset),
        .i_Valid           (i_Valid),
        .i_ALU_Result      (i_ALU_Result),
        .i_Write_Data      (i_Write_Data),
        .i_Write_Reg       (i_Write_Reg),
        .i_Sig_MemRead     (i_Sig_MemRead),
        .i_Sig_MemWrite    (i_Sig_MemWrite),
        .i_Sig_MemtoReg    (i_Sig_MemtoReg),
        .i_Sig_RegWrite    (i_Sig_RegWrite),
        .o_Stall           (o_Stall),
        .o_Valid           (o_Valid),
        .o_Write_Back_Data (o_Write_Back_Data),
        .o_Write_Reg       (o_Write_Reg),
        .o_Sig_RegWrite    (o_Sig_RegWrite),
        .o_Fault           (o_Fault)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] alu, input logic [15:0] wd,
                                 input logic [2:0] rg, input logic rd, input logic wr,
                                 input logic m2r, input logic rw);
        i_Valid        = v;
        i_ALU_Result   = alu;
        i_Write_Data   = wd;
        i_Write_Reg    = rg;
        i_Sig_MemRead  = rd;
        i_Sig_MemWrite = wr;
        i_Sig_MemtoReg = m2r;
        i_Sig_RegWrite = rw;
    endtask

    // Issues one instruction and waits (bounded) for its o_Valid pulse
    task automatic run_mem_op(input logic [15:0] alu, input logic [15:0] wd, input logic [2:0] rg,
                              input logic rd, input logic wr, input logic m2r, input logic rw,
                              output int lat, output int stalls, output logic [15:0] data,
                              output logic [2:0] reg_o, output logic rw_o, output logic fault_o);
        applyStimulus(1'b1, alu, wd, rg, rd, wr, m2r, rw);
        step();
        applyStimulus(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        lat = 1;
        stalls = 0;
        while (o_Valid !== 1'b1 && lat < 20) begin
            if (o_Stall === 1'b1) stalls++;
            step();
            lat++;
        end
        data    = o_Write_Back_Data;
        reg_o   = o_Write_Reg;
        rw_o    = o_Sig_RegWrite;
        fault_o = o_Fault;
    endtask

    task automatic test_reset();
        i_Reset = 1'b1;
        step();
        step();
        checks++;
        if (o_Stall !== 1'b0 || o_Valid !== 1'b0 || o_Sig_RegWrite !== 1'b0 || o_Fault !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got stall=%b valid=%b rw=%b fault=%b expected all 0",
                     o_Stall, o_Valid, o_Sig_RegWrite, o_Fault);
        end
        checks++;
        if (o_Write_Back_Data !== 16'h0 || o_Write_Reg !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_data: got data=%h reg=%0d expected 0000/0", o_Write_Back_Data, o_Write_Reg);
        end
        @(negedge i_Clk);
        i_Reset = 1'b0;
        step();
    endtask

    task automatic test_alu_op();
        applyStimulus(1'b1, 16'h1234, 16'h0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (o_Stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL alu_stall_before: got %b expected 0", o_Stall);
        end
        step();
        applyStimulus(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (o_Valid !== 1'b1 || o_Write_Back_Data !== 16'h1234 || o_Write_Reg !== 3'd3 ||
            o_Sig_RegWrite !== 1'b1 || o_Stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL alu_result: got v=%b d=%h r=%0d rw=%b st=%b expected 1/1234/3/1/0",
                     o_Valid, o_Write_Back_Data, o_Write_Reg, o_Sig_RegWrite, o_Stall);
        end
        step();
        checks++;
        if (o_Valid !== 1'b0 || o_Write_Back_Data !== 16'h1234 || o_Sig_RegWrite !== 1'b0) begin
            failures++;
            $display("[TB] FAIL alu_idle_hold: got v=%b d=%h rw=%b expected 0/1234/0",
                     o_Valid, o_Write_Back_Data, o_Sig_RegWrite);
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 16'h0001, 16'h0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checks++;
        if (o_Valid !== 1'b1 || o_Write_Back_Data !== 16'h0001 || o_Write_Reg !== 3'd1 || o_Sig_RegWrite !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_first: got v=%b d=%h r=%0d rw=%b expected 1/0001/1/1",
                     o_Valid, o_Write_Back_Data, o_Write_Reg, o_Sig_RegWrite);
        end
        applyStimulus(1'b1, 16'h0002, 16'h0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (o_Valid !== 1'b1 || o_Write_Back_Data !== 16'h0002 || o_Write_Reg !== 3'd2 || o_Sig_RegWrite !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_second: got v=%b d=%h r=%0d rw=%b expected 1/0002/2/0",
                     o_Valid, o_Write_Back_Data, o_Write_Reg, o_Sig_RegWrite);
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (o_Valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_drain: got valid=%b expected 0", o_Valid);
        end
    endtask

    task automatic test_store_load();
        int lat, stalls;
        logic [15:0] d;
        logic [2:0] r;
        logic rw, f;
        run_mem_op(16'h0010, 16'hBEEF, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, lat, stalls, d, r, rw, f);
        checks++;
        if (lat != LAT || stalls != LAT - 1) begin
            failures++;
            $display("[TB] FAIL sw_timing: got latency=%0d stalls=%0d expected %0d/%0d", lat, stalls, LAT, LAT - 1);
        end
        checks++;
        if (d !== 16'h0010 || rw !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sw_wb: got d=%h rw=%b expected 0010/0", d, rw);
        end
        run_mem_op(16'h0010, 16'h0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, lat, stalls, d, r, rw, f);
        checks++;
        if (lat != LAT || d !== 16'hBEEF || r !== 3'd5 || rw !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lw_data: got lat=%0d d=%h r=%0d rw=%b expected %0d/BEEF/5/1", lat, d, r, rw, LAT);
        end
    endtask

    task automatic test_stall_hold();
        logic exp_valid [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic exp_stall [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int pulses = 0;
        applyStimulus(1'b1, 16'h0010, 16'h0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        applyStimulus(1'b1, 16'h00AA, 16'h0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            if (o_Valid === 1'b1) pulses++;
            checks++;
            if (o_Valid !== exp_valid[c] || o_Stall !== exp_stall[c]) begin
                failures++;
                $display("[TB] FAIL hold_cycle%0d: got v=%b st=%b expected %b/%b",
                         c + 1, o_Valid, o_Stall, exp_valid[c], exp_stall[c]);
            end
            if (c == 2) begin
                checks++;
                if (o_Write_Back_Data !== 16'hBEEF || o_Write_Reg !== 3'd2) begin
                    failures++;
                    $display("[TB] FAIL hold_load: got d=%h r=%0d expected BEEF/2", o_Write_Back_Data, o_Write_Reg);
                end
            end
            if (c == 3) begin
                checks++;
                if (o_Write_Back_Data !== 16'h00AA || o_Write_Reg !== 3'd4) begin
                    failures++;
                    $display("[TB] FAIL hold_alu: got d=%h r=%0d expected 00AA/4", o_Write_Back_Data, o_Write_Reg);
                end
                applyStimulus(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            step();
        end
        checks++;
        if (pulses != 2) begin
            failures++;
            $display("[TB] FAIL hold_pulses: got %0d expected 2", pulses);
        end
    endtask

    task automatic test_reset_abort();
        int lat, stalls;
        logic [15:0] d;
        logic [2:0] r;
        logic rw, f;
        run_mem_op(16'h0020, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, lat, stalls, d, r, rw, f);
        applyStimulus(1'b1, 16'h0020, 16'h5555, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (o_Stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_busy: got stall=%b expected 1", o_Stall);
        end
        #1;
        i_Reset = 1'b1;
        #1;
        checks++;
        if (o_Stall !== 1'b0 || o_Valid !== 1'b0 || o_Write_Back_Data !== 16'h0 || o_Write_Reg !== 3'd0) begin
            failures++;
            $display("[TB] FAIL abort_outputs: got st=%b v=%b d=%h r=%0d expected 0/0/0000/0",
                     o_Stall, o_Valid, o_Write_Back_Data, o_Write_Reg);
        end
        @(negedge i_Clk);
        i_Reset = 1'b0;
        step();
        applyStimulus(1'b1, 16'h1111, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_mem_op(16'h0020, 16'h0, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, lat, stalls, d, r, rw, f);
        checks++;
        if (lat != LAT || d !== 16'h0000 || r !== 3'd7) begin
            failures++;
            $display("[TB] FAIL abort_no_commit: got lat=%0d d=%h r=%0d expected %0d/0000/7", lat, d, r, LAT);
        end
    endtask

    task automatic test_rw_conflict();
        int lat, stalls;
        logic [15:0] d;
        logic [2:0] r;
        logic rw, f;
        run_mem_op(16'h0005, 16'h7777, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1, lat, stalls, d, r, rw, f);
        checks++;
        if (lat != LAT || d !== 16'h0005 || r !== 3'd6 || rw !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rw_wb: got lat=%0d d=%h r=%0d rw=%b expected %0d/0005/6/1", lat, d, r, rw, LAT);
        end
        run_mem_op(16'h0005, 16'h0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, lat, stalls, d, r, rw, f);
        checks++;
        if (d !== 16'h7777) begin
            failures++;
            $display("[TB] FAIL rw_stored: got d=%h expected 7777", d);
        end
    endtask

    task automatic test_bounds();
        int lat, stalls;
        logic [15:0] d;
        logic [2:0] r;
        logic rw, f;
        logic [15:0] exp_word0 = BOUNDS ? 16'h1357 : 16'hA5A5;
        logic [15:0] exp_far   = BOUNDS ? 16'h0000 : 16'hA5A5;
        run_mem_op(16'h0000, 16'h1357, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, lat, stalls, d, r, rw, f);
        run_mem_op(16'h0100, 16'hA5A5, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, lat, stalls, d, r, rw, f);
        checks++;
        if (lat != LAT || f !== BOUNDS) begin
            failures++;
            $display("[TB] FAIL bounds_store: got lat=%0d fault=%b expected %0d/%b", lat, f, LAT, BOUNDS);
        end
        run_mem_op(16'h0000, 16'h0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, lat, stalls, d, r, rw, f);
        checks++;
        if (d !== exp_word0 || f !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bounds_word0: got d=%h fault=%b expected %h/0", d, f, exp_word0);
        end
        run_mem_op(16'h0100, 16'h0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, lat, stalls, d, r, rw, f);
        checks++;
        if (lat != LAT || d !== exp_far || f !== BOUNDS) begin
            failures++;
            $display("[TB] FAIL bounds_load: got lat=%0d d=%h fault=%b expected %0d/%h/%b",
                     lat, d, f, LAT, exp_far, BOUNDS);
        end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_back_to_back();
        test_store_load();
        test_stall_hold();
        test_reset_abort();
        test_rw_conflict();
        test_bounds();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
